// File: rtl/stall_buffer_pkg.sv
// Shared constants for the stall_buffer catch buffer: default word width and
// the pointer-width helper used to size the circular-buffer indices.
package stall_buffer_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stall_buffer_mem.sv
// Depth x DataWidth register array for stall_buffer: one synchronous write
// port and one combinational read port; contents are never reset.
module stall_buffer_mem
  import stall_buffer_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH_DEFAULT,
  parameter int Depth     = 4,
  parameter int PtrW      = ptr_width(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [PtrW-1:0]      waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [PtrW-1:0]      raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_r [Depth];

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/stall_buffer.sv
// Receive-side catch buffer for a fixed-latency launch path: stores arriving
// words and raises stall early enough that every in-flight word finds room.
module stall_buffer
  import stall_buffer_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH_DEFAULT,
  parameter int Depth     = 4,
  parameter int Latency   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   wr_valid_i,
  input  logic [DataWidth-1:0]   wr_data_i,
  output logic                   stall_o,
  output logic                   rd_valid_o,
  output logic [DataWidth-1:0]   rd_data_o,
  input  logic                   rd_ready_i,
  output logic [$clog2(Depth):0] count_o,
  output logic                   overflow_o
);

  localparam int PtrW = ptr_width(Depth);
  localparam int CntW = $clog2(Depth) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  // Latency entries stay reserved for words already launched.
  localparam logic [CntW-1:0] StallThr = CntW'(Depth - Latency);

  logic [PtrW-1:0] wr_ptr_r;
  logic [PtrW-1:0] rd_ptr_r;
  logic [CntW-1:0] count_r;
  logic [CntW-1:0] count_next_s;
  logic            rd_valid_r;
  logic            stall_r;
  logic            overflow_r;
  logic            read_fire_s;
  logic            write_fire_s;
  logic            drop_s;
  logic            mem_we_s;

  assign read_fire_s  = rd_valid_r && rd_ready_i;
  assign write_fire_s = wr_valid_i && ((count_r != DepthCnt) || read_fire_s);
  assign drop_s       = wr_valid_i && !write_fire_s;
  assign mem_we_s     = write_fire_s && !flush_i && !rst_i;

  // Occupancy after this cycle's read/write.
  always_comb begin
    count_next_s = count_r;
    if (write_fire_s && !read_fire_s) begin
      count_next_s = count_r + CntW'(1);
    end else if (read_fire_s && !write_fire_s) begin
      count_next_s = count_r - CntW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, occupancy and the flags registered from next occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      rd_valid_r <= 1'b0;
      stall_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      rd_valid_r <= 1'b0;
      stall_r    <= 1'b0;
      overflow_r <= overflow_r;
    end else begin
      if (write_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PtrW'(1);
      end
      if (read_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1);
      end
      count_r    <= count_next_s;
      rd_valid_r <= (count_next_s != '0);
      stall_r    <= (count_next_s >= StallThr);
      overflow_r <= overflow_r | drop_s;
    end
  end

  stall_buffer_mem #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .PtrW      (PtrW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we_s),
    .waddr_i (wr_ptr_r),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_r),
    .rdata_o (rd_data_o)
  );

  assign stall_o    = stall_r;
  assign rd_valid_o = rd_valid_r;
  assign count_o    = count_r;
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_stall_buffer.sv
// Scoreboard bench for stall_buffer: directed tests on a Latency=1 instance
// and a random back-pressure run on a Latency=2 instance fed by a delay line.
module tb_stall_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush1, wv1, rr1, st1, rv1, ov1;
  logic [31:0] wd1, rd1;
  logic [2:0]  cnt1;
  logic        flush2, wv2, rr2, st2, rv2, ov2;
  logic [31:0] wd2, rd2;
  logic [2:0]  cnt2;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb1[$];
  logic [31:0] sb2[$];
  logic        ovf_m;

  stall_buffer #(.DataWidth(32), .Depth(4), .Latency(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush1), .wr_valid_i(wv1), .wr_data_i(wd1),
    .stall_o(st1), .rd_valid_o(rv1), .rd_data_o(rd1), .rd_ready_i(rr1),
    .count_o(cnt1), .overflow_o(ov1)
  );

  stall_buffer #(.DataWidth(32), .Depth(4), .Latency(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush2), .wr_valid_i(wv2), .wr_data_i(wd2),
    .stall_o(st2), .rd_valid_o(rv2), .rd_data_o(rd2), .rd_ready_i(rr2),
    .count_o(cnt2), .overflow_o(ov2)
  );

  // Advance one cycle on instance 1, pushing accepted words and popping the
  // expected head when the reference model says a read fires.
  task automatic tick1(output logic fired, output logic [31:0] exp, output logic [31:0] got);
    logic full;
    fired = 1'b0;
    exp   = 32'h0;
    got   = rd1;
    full  = (sb1.size() == 4);
    if (rst) begin
      sb1.delete();
      ovf_m = 1'b0;
    end else if (flush1) begin
      sb1.delete();
    end else begin
      if (sb1.size() != 0 && rr1) begin
        fired = 1'b1;
        exp   = sb1.pop_front();
      end
      if (wv1) begin
        if (!full || fired) sb1.push_back(wd1);
        else ovf_m = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic f; logic [31:0] e, g;
    rst = 1'b1; flush1 = 1'b0; wv1 = 1'b0; rr1 = 1'b0; wd1 = 32'h0;
    tick1(f, e, g); tick1(f, e, g);
    rst = 1'b0;
    checks += 5;
    if (rv1 !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rv1); end
    if (cnt1 !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt1); end
    if (st1 !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", st1); end
    if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", ov1); end
    if (rv2 !== 1'b0 || cnt2 !== 3'd0 || ov2 !== 1'b0 || st2 !== 1'b0) begin
      errors++; $display("FAIL reset_dut2: got v=%b c=%0d o=%b s=%b want 0", rv2, cnt2, ov2, st2);
    end
    wv1 = 1'b1; wd1 = 32'hA5A5A5A5;
    tick1(f, e, g);
    wv1 = 1'b0;
    checks += 3;
    if (rv1 !== 1'b1) begin errors++; $display("FAIL first_write_valid: got %b want 1", rv1); end
    if (cnt1 !== 3'd1) begin errors++; $display("FAIL first_write_count: got %0d want 1", cnt1); end
    if (rd1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL first_write_data: got %h want a5a5a5a5", rd1); end
    tick1(f, e, g);
    checks++;
    if (rv1 !== 1'b1 || rd1 !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL hold_stable: got v=%b d=%h want v=1 d=a5a5a5a5", rv1, rd1);
    end
    rr1 = 1'b1;
    tick1(f, e, g);
    rr1 = 1'b0;
    checks += 2;
    if (!f || g !== e) begin errors++; $display("FAIL reset_drain: got %h want %h", g, e); end
    if (cnt1 !== 3'd0) begin errors++; $display("FAIL reset_drain_count: got %0d want 0", cnt1); end
  endtask

  task automatic test_full_simultaneous;
    logic f; logic [31:0] e, g;
    for (int i = 1; i <= 4; i++) begin
      wv1 = 1'b1; wd1 = 32'(i);
      tick1(f, e, g);
    end
    wv1 = 1'b1; wd1 = 32'h55; rr1 = 1'b1;
    tick1(f, e, g);
    wv1 = 1'b0;
    checks += 3;
    if (!f || g !== e || g !== 32'h1) begin errors++; $display("FAIL full_simul_read: got %h want 1", g); end
    if (cnt1 !== 3'd4) begin errors++; $display("FAIL full_simul_count: got %0d want 4", cnt1); end
    if (ov1 !== 1'b0) begin errors++; $display("FAIL full_simul_overflow: got %b want 0", ov1); end
    for (int k = 0; k < 4; k++) begin
      tick1(f, e, g);
      checks++;
      if (!f || g !== e) begin errors++; $display("FAIL full_simul_drain%0d: got %h want %h", k, g, e); end
    end
    rr1 = 1'b0;
    checks += 2;
    if (g !== 32'h55) begin errors++; $display("FAIL full_simul_last: got %h want 55", g); end
    if (rv1 !== 1'b0) begin errors++; $display("FAIL full_simul_empty: got %b want 0", rv1); end
  endtask

  task automatic test_fill;
    logic f; logic [31:0] e, g;
    for (int i = 1; i <= 4; i++) begin
      wv1 = 1'b1; wd1 = 32'(i);
      tick1(f, e, g);
      checks += 2;
      if (cnt1 !== 3'(i)) begin errors++; $display("FAIL fill_count%0d: got %0d want %0d", i, cnt1, i); end
      if (st1 !== (i >= 3)) begin errors++; $display("FAIL fill_stall%0d: got %b want %b", i, st1, (i >= 3)); end
    end
    wd1 = 32'h5;
    tick1(f, e, g);
    wv1 = 1'b0;
    checks += 2;
    if (cnt1 !== 3'd4) begin errors++; $display("FAIL drop_count: got %0d want 4", cnt1); end
    if (ov1 !== 1'b1) begin errors++; $display("FAIL drop_overflow: got %b want 1", ov1); end
    rr1 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick1(f, e, g);
      checks++;
      if (!f || g !== e || g !== 32'(k)) begin errors++; $display("FAIL fill_drain%0d: got %h want %h", k, g, k); end
    end
    rr1 = 1'b0;
    checks++;
    if (rv1 !== 1'b0 || st1 !== 1'b0) begin errors++; $display("FAIL fill_empty: got v=%b s=%b want 0", rv1, st1); end
  endtask

  task automatic test_flush;
    logic f; logic [31:0] e, g;
    for (int i = 0; i < 3; i++) begin
      wv1 = 1'b1; wd1 = 32'h10 + 32'(i);
      tick1(f, e, g);
    end
    checks++;
    if (cnt1 !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", cnt1); end
    flush1 = 1'b1; wd1 = 32'h77;
    tick1(f, e, g);
    flush1 = 1'b0; wv1 = 1'b0;
    checks += 3;
    if (cnt1 !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", cnt1); end
    if (rv1 !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", rv1); end
    if (ov1 !== ovf_m) begin errors++; $display("FAIL flush_overflow: got %b want %b", ov1, ovf_m); end
    wv1 = 1'b1; wd1 = 32'h88;
    tick1(f, e, g);
    wv1 = 1'b0; rr1 = 1'b1;
    tick1(f, e, g);
    rr1 = 1'b0;
    checks += 2;
    if (!f || g !== e || g !== 32'h88) begin errors++; $display("FAIL flush_head: got %h want 88", g); end
    if (cnt1 !== 3'd0) begin errors++; $display("FAIL flush_post_count: got %0d want 0", cnt1); end
  endtask

  task automatic test_streaming;
    logic f; logic [31:0] e, g;
    rr1 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      wv1 = 1'b1; wd1 = 32'(i);
      tick1(f, e, g);
      if (i > 0) begin
        checks++;
        if (!f || g !== e || g !== 32'(i - 1)) begin
          errors++; $display("FAIL stream_data%0d: got %h want %h", i - 1, g, i - 1);
        end
      end
      checks++;
      if (cnt1 > 3'd1) begin errors++; $display("FAIL stream_count%0d: got %0d want <=1", i, cnt1); end
    end
    wv1 = 1'b0;
    tick1(f, e, g);
    rr1 = 1'b0;
    checks += 2;
    if (!f || g !== e || g !== 32'd63) begin errors++; $display("FAIL stream_last: got %h want 3f", g); end
    if (cnt1 !== 3'd0) begin errors++; $display("FAIL stream_end_count: got %0d want 0", cnt1); end
  endtask

  // Latency=2 delay line between launch and wr_*; upstream launches only
  // when it samples stall low.
  task automatic test_back_to_back;
    logic        s0v, s1v, launch, fire;
    logic [31:0] s0d, s1d, data, exp, got;
    int launched, received, cyc;
    s0v = 1'b0; s1v = 1'b0; s0d = 32'h0; s1d = 32'h0;
    launched = 0; received = 0; cyc = 0;
    sb2.delete();
    while (received < 10000 && cyc < 45000) begin
      wv2 = s1v; wd2 = s1d;
      rr2 = 1'($urandom_range(0, 1));
      launch = !st2 && (launched < 10000);
      data = $urandom;
      if (launch) begin
        sb2.push_back(data);
        launched++;
      end
      got  = rd2;
      fire = rv2 && rr2;
      if (fire) begin
        checks++;
        if (sb2.size() == 0) begin
          errors++; $display("FAIL random_extra_word: got %h want none", got);
        end else begin
          exp = sb2.pop_front();
          if (got !== exp) begin errors++; $display("FAIL random_data%0d: got %h want %h", received, got, exp); end
        end
        received++;
      end
      s1v = s0v; s1d = s0d;
      s0v = launch; s0d = data;
      @(posedge clk); #1;
      cyc++;
    end
    wv2 = 1'b0; rr2 = 1'b0;
    checks += 3;
    if (received !== 10000) begin errors++; $display("FAIL random_timeout: got %0d words want 10000", received); end
    if (ov2 !== 1'b0) begin errors++; $display("FAIL random_overflow: got %b want 0", ov2); end
    if (cnt2 !== 3'd0) begin errors++; $display("FAIL random_end_count: got %0d want 0", cnt2); end
  endtask

  initial begin
    rst = 1'b1; flush1 = 1'b0; wv1 = 1'b0; rr1 = 1'b0; wd1 = 32'h0;
    flush2 = 1'b0; wv2 = 1'b0; rr2 = 1'b0; wd2 = 32'h0; ovf_m = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_full_simultaneous();
    test_fill();
    test_flush();
    test_streaming();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
